// File: rtl/rgb2ycbcr_mac.sv
// Serial R,G,B multiply-accumulate colour converter producing one clamped
// 8-bit Y/Cb/Cr component per pixel, three samples in, one result out.
module rgb2ycbcr_mac #(
    parameter logic signed [15:0] C0     = 16'sd2449,
    parameter logic signed [15:0] C1     = 16'sd4809,
    parameter logic signed [15:0] C2     = 16'sd934,
    parameter logic signed [26:0] OFFSET = 27'sd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       dvalid_in,
    input  logic       sop_in,
    input  logic [7:0] vdata_in,
    output logic       dvalid_out,
    output logic [7:0] vdata_out,
    output logic       sat_out
);

    logic [1:0]         phase_q, phase_d;
    logic signed [23:0] prod_q, prod_d;
    logic [1:0]         tag_q, tag_d;
    logic               pv_q, pv_d;
    logic signed [26:0] acc_q, acc_d;
    logic               done_q, done_d;
    logic               dv_q, dv_d;
    logic [7:0]         vout_q, vout_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic [1:0]         cur_ph;
    logic signed [15:0] coef;
    logic signed [24:0] samp_s, coef_s, prod_full;
    logic signed [26:0] prod_x;

    always_comb begin
        accept = clk_en & dvalid_in;
        cur_ph = sop_in ? 2'd0 : phase_q;
        case (cur_ph)
            2'd0:    coef = C0;
            2'd1:    coef = C1;
            default: coef = C2;
        endcase
        samp_s    = {17'b0, vdata_in};
        coef_s    = {{9{coef[15]}}, coef};
        prod_full = samp_s * coef_s;
        prod_x    = {{3{prod_q[23]}}, prod_q};
    end

    // Stage 1: phase tracking and product register
    always_comb begin
        phase_d = phase_q;
        prod_d  = prod_q;
        tag_d   = tag_q;
        pv_d    = pv_q;
        if (clk_en) begin
            pv_d = dvalid_in;
        end
        if (accept) begin
            phase_d = (cur_ph == 2'd2) ? 2'd0 : cur_ph + 2'd1;
            prod_d  = prod_full[23:0];
            tag_d   = cur_ph;
        end
    end

    // Stage 2: accumulate; an R product restarts the sum with rounding
    always_comb begin
        acc_d  = acc_q;
        done_d = done_q;
        if (clk_en) begin
            done_d = pv_q && (tag_q == 2'd2);
            if (pv_q) begin
                if (tag_q == 2'd0) begin
                    acc_d = prod_x + OFFSET + 27'sd4096;
                end else begin
                    acc_d = acc_q + prod_x;
                end
            end
        end
    end

    // Stage 3: clamp the closed sum into the output register
    always_comb begin
        dv_d   = dv_q;
        vout_d = vout_q;
        sat_d  = sat_q;
        if (clk_en) begin
            dv_d = done_q;
            if (done_q) begin
                if (acc_q[26]) begin
                    vout_d = 8'd0;
                    sat_d  = 1'b1;
                end else if (acc_q[25:13] >= 13'd256) begin
                    vout_d = 8'd255;
                    sat_d  = 1'b1;
                end else begin
                    vout_d = acc_q[20:13];
                    sat_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= 2'd0;
            prod_q  <= '0;
            tag_q   <= 2'd0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
            vout_q  <= 8'd0;
            sat_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            prod_q  <= prod_d;
            tag_q   <= tag_d;
            pv_q    <= pv_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
            vout_q  <= vout_d;
            sat_q   <= sat_d;
        end
    end

    assign dvalid_out = dv_q;
    assign vdata_out  = vout_q;
    assign sat_out    = sat_q;

endmodule
